// File: rtl/phase_sequence_checker_pkg.sv
// Shared definitions for four-phase clock consumers: FSM encoding and
// the one-hot phase constants for [0:3] vectors.
package phase_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_e;

  localparam int unsigned PHASE_N = 4;

  localparam logic [0:3] PH0 = 4'b1000;
  localparam logic [0:3] PH1 = 4'b0100;
  localparam logic [0:3] PH2 = 4'b0010;
  localparam logic [0:3] PH3 = 4'b0001;

  // Successor in the strict 0->1->2->3->0 rotation.
  function automatic logic [1:0] next_phase(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/phase_sequence_checker_if.sv
// Phase input and status outputs of the four-phase sequence checker.
interface phase_sequence_checker_if #(
  parameter int unsigned CNT_WIDTH = 16
);

  logic [0:3]           Phase;
  logic                 Enable;
  logic [1:0]           PhaseIndex;
  logic                 PhaseValid;
  logic                 Locked;
  logic                 CycleStart;
  logic                 SeqError;
  logic [CNT_WIDTH-1:0] CycleCount;
  logic [7:0]           ErrorCount;

  modport master (
    output Phase, Enable,
    input  PhaseIndex, PhaseValid, Locked, CycleStart, SeqError,
           CycleCount, ErrorCount
  );

  modport slave (
    input  Phase, Enable,
    output PhaseIndex, PhaseValid, Locked, CycleStart, SeqError,
           CycleCount, ErrorCount
  );

endinterface

// File: rtl/phase_sequence_checker_onehot4_decode.sv
// Combinational decoder for a [0:3] one-hot phase vector: reports whether
// exactly one bit is set and the position of that bit.
module onehot4_decode
  import phase_pkg::*;
(
  input  logic [0:3] vec_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  always_comb begin
    valid_o = 1'b1;
    idx_o   = '0;
    case (vec_i)
      PH0:     idx_o = 2'd0;
      PH1:     idx_o = 2'd1;
      PH2:     idx_o = 2'd2;
      PH3:     idx_o = 2'd3;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/phase_sequence_checker.sv
// Checks that the four-phase clock vector advances in strict rotation,
// declares lock after a run of good transitions and counts rotations/errors.
module phase_sequence_checker
  import phase_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  phase_sequence_checker_if.slave  ph
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  state_e               state_q, state_d;
  logic [3:0]           good_q, good_d;
  logic [1:0]           idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 cstart_q, cstart_d;
  logic                 serr_q, serr_d;
  logic [CNT_WIDTH-1:0] ccnt_q, ccnt_d;
  logic [7:0]           ecnt_q, ecnt_d;

  logic                 smp_valid;
  logic [1:0]           smp_idx;
  logic                 smp_next;

  onehot4_decode u_decode (
    .vec_i   (ph.Phase),
    .valid_o (smp_valid),
    .idx_o   (smp_idx)
  );

  assign smp_next = (smp_idx == next_phase(idx_q));

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    cstart_d = 1'b0;
    serr_d   = 1'b0;
    ccnt_d   = ccnt_q;
    ecnt_d   = ecnt_q;

    if (ph.Enable) begin
      if (!smp_valid) begin
        serr_d  = 1'b1;
        valid_d = 1'b0;
        state_d = IDLE;
        good_d  = '0;
        if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
      end else begin
        idx_d   = smp_idx;
        valid_d = 1'b1;
        case (state_q)
          IDLE: begin
            good_d  = '0;
            state_d = TRACK;
          end
          TRACK: begin
            if (smp_next) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_TARGET) state_d = LOCKED;
            end else begin
              serr_d = 1'b1;
              good_d = '0;
              if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
            end
          end
          LOCKED: begin
            if (smp_next) begin
              if (smp_idx == 2'd0) begin
                cstart_d = 1'b1;
                ccnt_d   = ccnt_q + 1'b1;
              end
            end else begin
              serr_d  = 1'b1;
              good_d  = '0;
              state_d = TRACK;
              if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
            end
          end
          default: begin
            good_d  = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      good_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      cstart_q <= 1'b0;
      serr_q   <= 1'b0;
      ccnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      cstart_q <= cstart_d;
      serr_q   <= serr_d;
      ccnt_q   <= ccnt_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign ph.PhaseIndex = idx_q;
  assign ph.PhaseValid = valid_q;
  assign ph.Locked     = (state_q == LOCKED);
  assign ph.CycleStart = cstart_q;
  assign ph.SeqError   = serr_q;
  assign ph.CycleCount = ccnt_q;
  assign ph.ErrorCount = ecnt_q;

endmodule

// File: tb/tb_phase_sequence_checker.sv
// Directed bench for phase_sequence_checker; a 4-bit CycleCount instance
// shares the same stimulus to exercise counter wrap.
module tb_phase_sequence_checker;

  logic Clock;
  logic Reset;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned se_seen;

  phase_sequence_checker_if #(.CNT_WIDTH(16)) ifa ();
  phase_sequence_checker_if #(.CNT_WIDTH(4))  ifb ();

  phase_sequence_checker #(.LOCK_COUNT(4), .CNT_WIDTH(16)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .ph    (ifa)
  );

  phase_sequence_checker #(.LOCK_COUNT(4), .CNT_WIDTH(4)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .ph    (ifb)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample on the falling edge, then settle past the rising edge.
  task automatic step(input logic [0:3] p, input logic en, input logic rst);
    @(negedge Clock);
    Reset      = rst;
    ifa.Phase  = p;
    ifa.Enable = en;
    ifb.Phase  = p;
    ifb.Enable = en;
    @(posedge Clock);
    #1;
    if (ifa.SeqError) se_seen++;
  endtask

  task automatic rotation();
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_idx"},   32'(ifa.PhaseIndex), 0);
    chk({tag, "_valid"}, 32'(ifa.PhaseValid), 0);
    chk({tag, "_lock"},  32'(ifa.Locked), 0);
    chk({tag, "_cs"},    32'(ifa.CycleStart), 0);
    chk({tag, "_se"},    32'(ifa.SeqError), 0);
    chk({tag, "_cc"},    32'(ifa.CycleCount), 0);
    chk({tag, "_ec"},    32'(ifa.ErrorCount), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    se_seen = 0;
    Reset      = 1'b1;
    ifa.Phase  = 4'b0000;
    ifa.Enable = 1'b0;
    ifb.Phase  = 4'b0000;
    ifb.Enable = 1'b0;

    // Reset state
    step(4'b1000, 1'b1, 1'b1);
    step(4'b1000, 1'b1, 1'b1);
    chk_reset_state("rst");

    // Acquire lock: reference + 4 good transitions
    step(4'b1000, 1'b1, 1'b0);
    chk("ref_idx",   32'(ifa.PhaseIndex), 0);
    chk("ref_valid", 32'(ifa.PhaseValid), 1);
    chk("ref_lock",  32'(ifa.Locked), 0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    chk("e4_lock", 32'(ifa.Locked), 0);
    step(4'b1000, 1'b1, 1'b0);
    chk("e5_lock", 32'(ifa.Locked), 1);
    chk("e5_cs",   32'(ifa.CycleStart), 0);
    chk("e5_cc",   32'(ifa.CycleCount), 0);
    rotation();
    chk("first_cs", 32'(ifa.CycleStart), 1);
    chk("first_cc", 32'(ifa.CycleCount), 1);
    for (int i = 0; i < 9; i++) rotation();
    chk("rot_cc",    32'(ifa.CycleCount), 10);
    chk("rot_lock",  32'(ifa.Locked), 1);
    chk("rot_ec",    32'(ifa.ErrorCount), 0);
    chk("rot_noerr", se_seen, 0);

    // Out-of-order phase while locked
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("ooo_se",   32'(ifa.SeqError), 1);
    chk("ooo_ec",   32'(ifa.ErrorCount), 1);
    chk("ooo_lock", 32'(ifa.Locked), 0);
    chk("ooo_idx",  32'(ifa.PhaseIndex), 1);
    chk("ooo_cc",   32'(ifa.CycleCount), 10);
    step(4'b0010, 1'b1, 1'b0);
    chk("ooo_se_clr", 32'(ifa.SeqError), 0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk("relock3", 32'(ifa.Locked), 0);
    chk("relock3_cs", 32'(ifa.CycleStart), 0);
    step(4'b0100, 1'b1, 1'b0);
    chk("relock4", 32'(ifa.Locked), 1);

    // Reset mid-rotation, then invalid samples
    step(4'b0010, 1'b1, 1'b1);
    chk_reset_state("midrst");
    se_seen = 0;
    step(4'b0000, 1'b1, 1'b0);
    chk("zero_se",    32'(ifa.SeqError), 1);
    chk("zero_valid", 32'(ifa.PhaseValid), 0);
    step(4'b1100, 1'b1, 1'b0);
    chk("multi_se",    32'(ifa.SeqError), 1);
    chk("multi_ec",    32'(ifa.ErrorCount), 2);
    chk("multi_valid", 32'(ifa.PhaseValid), 0);
    chk("multi_idx",   32'(ifa.PhaseIndex), 0);
    chk("inv_pulses",  se_seen, 2);
    step(4'b0010, 1'b1, 1'b0);
    chk("fresh_idx",   32'(ifa.PhaseIndex), 2);
    chk("fresh_valid", 32'(ifa.PhaseValid), 1);
    chk("fresh_se",    32'(ifa.SeqError), 0);
    chk("fresh_ec",    32'(ifa.ErrorCount), 2);

    // Enable gating during a locked rotation
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    chk("en_lock", 32'(ifa.Locked), 1);
    se_seen = 0;
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk("en_cs", 32'(ifa.CycleStart), 1);
    chk("en_cc", 32'(ifa.CycleCount), 1);
    step(4'b1000, 1'b0, 1'b0);
    chk("dis_cs",  32'(ifa.CycleStart), 0);
    chk("dis_cc",  32'(ifa.CycleCount), 1);
    chk("dis_idx", 32'(ifa.PhaseIndex), 0);
    step(4'b1000, 1'b0, 1'b0);
    chk("dis2_lock",  32'(ifa.Locked), 1);
    chk("dis2_valid", 32'(ifa.PhaseValid), 1);
    step(4'b0100, 1'b1, 1'b0);
    chk("resume_idx",  32'(ifa.PhaseIndex), 1);
    chk("resume_lock", 32'(ifa.Locked), 1);
    chk("resume_ec",   32'(ifa.ErrorCount), 2);
    chk("en_noerr",    se_seen, 0);

    // CycleCount wrap on the 4-bit instance
    step(4'b1000, 1'b1, 1'b1);
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk("wrap_lock", 32'(ifb.Locked), 1);
    for (int r = 1; r <= 17; r++) begin
      rotation();
      if (r == 15) chk("wrap_b15", 32'(ifb.CycleCount), 15);
      if (r == 16) chk("wrap_b16", 32'(ifb.CycleCount), 0);
    end
    chk("wrap_b17", 32'(ifb.CycleCount), 1);
    chk("wrap_a17", 32'(ifa.CycleCount), 17);

    // ErrorCount saturation, then reset
    for (int i = 1; i <= 300; i++) begin
      step(((i % 2) == 0) ? 4'b0000 : 4'b1111, 1'b1, 1'b0);
      if (i == 254) chk("sat_254", 32'(ifa.ErrorCount), 254);
      if (i == 255) chk("sat_255", 32'(ifa.ErrorCount), 255);
    end
    chk("sat_300",    32'(ifa.ErrorCount), 255);
    chk("sat_se",     32'(ifa.SeqError), 1);
    chk("sat_lock",   32'(ifa.Locked), 0);
    chk("sat_cc",     32'(ifa.CycleCount), 17);
    step(4'b0000, 1'b1, 1'b1);
    chk_reset_state("endrst");
    chk("endrst_b_cc", 32'(ifb.CycleCount), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequence_checker.md
Name: phase_sequence_checker

Overview:
- Receiving end of the four-phase clock interface: samples the one-hot Phase[0:3] vector that sequences fetch/decode/execute/writeback in the SoC.
- Decodes the vector to a 2-bit phase index and checks that phases arrive in strict rotation 0→1→2→3→0.
- Declares lock after a run of good transitions, counts completed rotations and reports sequence errors.
- Sits beside the CPU control unit; Locked gates instruction issue, and the error outputs feed the debug/status register.

Parameters:
- LOCK_COUNT, 4, consecutive correct transitions required to enter LOCKED (range 1..15).
- CNT_WIDTH, 16, width of CycleCount.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Phase  in  [0:3]  one-hot phase vector; Phase[0]=1 (4'b1000) is phase 0, Phase[3]=1 (4'b0001) is phase 3.
- Enable  in  1  sample qualifier; Phase is evaluated only on edges where Enable=1.
- PhaseIndex  out  2  registered index of the last valid sample.
- PhaseValid  out  1  last sample was exactly one-hot.
- Locked  out  1  high while the FSM is in LOCKED.
- CycleStart  out  1  one-cycle pulse when phase 0 is accepted in LOCKED.
- SeqError  out  1  one-cycle pulse on any rejected sample.
- CycleCount  out  CNT_WIDTH  completed rotations while locked; wraps modulo 2^CNT_WIDTH.
- ErrorCount  out  8  rejected samples; saturates at 255.

Behaviour:
- All outputs are registered. A sample taken on edge k is reflected on the outputs after edge k. Latency is 1 cycle.
- Reset=1 at an edge takes priority over everything. It forces:
  - state=IDLE, PhaseIndex=0, PhaseValid=0, Locked=0, CycleStart=0, SeqError=0, CycleCount=0, ErrorCount=0, good-run counter=0.
  - Reset mid-rotation discards all history. The next valid sample is treated as a fresh reference.
- Enable=0: state, counters, PhaseIndex and PhaseValid hold. CycleStart and SeqError return to 0.
- Sample classification on each enabled edge:
  - valid = exactly one bit of Phase set.
  - idx = encoded position of that bit.
  - expected = (PhaseIndex+1) mod 4, 2-bit wrap.
- Invalid sample (0000, or two or more bits set) in any state:
  - SeqError=1, ErrorCount+1, PhaseValid=0, PhaseIndex holds.
  - state→IDLE, good-run cleared.
- IDLE + valid sample: PhaseIndex=idx, PhaseValid=1, good-run=0, →TRACK. No error is flagged in IDLE.
- TRACK + valid sample:
  - idx==expected: good-run+1. When good-run reaches LOCK_COUNT, →LOCKED and Locked=1 on that edge.
  - idx!=expected: SeqError=1, ErrorCount+1, good-run=0, stay in TRACK, and idx becomes the new reference.
- LOCKED + valid sample:
  - idx==expected: stay in LOCKED.
    - If idx==0: CycleStart=1 and CycleCount+1.
    - The first accepted phase 0 after lock counts as a rotation.
  - idx!=expected (this includes a repeated phase): SeqError=1, ErrorCount+1, Locked=0, →TRACK with good-run=0 and reference=idx.
- PhaseIndex and PhaseValid update on every valid sample in every state.
- CycleCount wraps silently from all-ones to 0. ErrorCount holds at 255.
- CycleStart and SeqError are mutually exclusive by construction.

Decomposition:
- Shared package `phase_pkg` holds:
  - FSM state encoding: IDLE=2'b00, TRACK=2'b01, LOCKED=2'b10.
  - PHASE_N=4.
  - One-hot phase constants PH0..PH3 = 4'b1000, 4'b0100, 4'b0010, 4'b0001.
- One natural sub-module `onehot4_decode`: a combinational valid/idx decoder for [0:3] vectors. It can be reused by other phase consumers.
- FSM and counters stay in the top module.

Test Plan:
- Reset=1 for 2 cycles, then Enable=1 with Phase rotating 1000,0100,0010,0001… from the four-phase generator, LOCK_COUNT=4:
  - Locked rises on the 5th enabled edge (reference + 4 good transitions).
  - The first CycleStart appears at the next accepted 1000.
  - After 10 further rotations, CycleCount=10.
  - SeqError is never asserted.
- While locked, inject 0100 where 0010 was expected:
  - SeqError pulses once, ErrorCount=1, Locked=0, PhaseIndex=1.
  - Locked returns after 4 more correct transitions.
- Drive 0000 for one sample, then 1100 for one sample:
  - Two SeqError pulses, ErrorCount=2, PhaseValid=0, state IDLE.
  - The next valid 0010 gives PhaseIndex=2 with no error.
- Toggle Enable 1,0,0,1 during a locked rotation while Phase stays static on the disabled cycles:
  - No error, counters hold.
  - The rotation continues from the held PhaseIndex.
- CNT_WIDTH=4, run 17 locked rotations:
  - CycleCount wraps 15→0 and reads 1 at the end.
- Apply 300 invalid samples:
  - ErrorCount saturates at 255.
  - Assert Reset mid-stream: all outputs return to reset values on the next edge.
